// File: rtl/axi_lite_uart_master.sv
// AXI4-Lite initiator: one user command becomes one AXI-Lite transaction and one response.
// A per-transaction watchdog frees the bus from a hung slave and reports resp=2'b11 with timeout set.
//  state    | meaning
//  IDLE     | waiting for a command
//  WR       | AW and W outstanding
//  WR_RESP  | waiting for B
//  RD_ADDR  | AR outstanding
//  RD_DATA  | waiting for R
//  RSP      | response held until consumed
module axi_lite_uart_master #(
   parameter int P_M_AXI_DATA_WIDTH = 32,
   parameter int P_M_AXI_ADDR_WIDTH = 16,
   parameter int P_TIMEOUT          = 1024
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic                          i_cmd_write,
   input  logic [P_M_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
   input  logic [P_M_AXI_DATA_WIDTH-1:0] i_cmd_wdata,
   output logic                          o_rsp_valid,
   input  logic                          i_rsp_ready,
   output logic [P_M_AXI_DATA_WIDTH-1:0] o_rsp_rdata,
   output logic [1:0]                    o_rsp_resp,
   output logic                          o_rsp_timeout,
   output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                          m_axi_awvalid,
   input  logic                          m_axi_awready,
   output logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_wdata,
   output logic                          m_axi_wvalid,
   input  logic                          m_axi_wready,
   input  logic [1:0]                    m_axi_bresp,
   input  logic                          m_axi_bvalid,
   output logic                          m_axi_bready,
   output logic [P_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                          m_axi_arvalid,
   input  logic                          m_axi_arready,
   input  logic [P_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]                    m_axi_rresp,
   input  logic                          m_axi_rvalid,
   output logic                          m_axi_rready
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RSP
   } state_t;

   localparam bit          LP_TMO_EN   = (P_TIMEOUT != 0);
   localparam logic [15:0] LP_TMO_LAST = LP_TMO_EN ? 16'(P_TIMEOUT - 1) : 16'd0;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic                            w_cmd_hs;
   logic                            w_busy;
   logic                            w_done;
   logic                            w_tmo_hit;
   logic                            w_abort;
   logic [15:0]                     r_tcnt;
   logic [P_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
   logic [P_M_AXI_ADDR_WIDTH-1:0]   r_araddr;
   logic [P_M_AXI_DATA_WIDTH-1:0]   r_wdata;
   logic                            r_awvalid;
   logic                            r_wvalid;
   logic                            r_bready;
   logic                            r_arvalid;
   logic                            r_rready;
   logic [P_M_AXI_DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]                      r_rsp_resp;
   logic                            r_rsp_timeout;

   assign o_cmd_ready   = (r_state == ST_IDLE);
   assign o_rsp_valid   = (r_state == ST_RSP);
   assign o_rsp_rdata   = r_rsp_rdata;
   assign o_rsp_resp    = r_rsp_resp;
   assign o_rsp_timeout = r_rsp_timeout;
   assign m_axi_awaddr  = r_awaddr;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_rready  = r_rready;

   assign w_cmd_hs  = i_cmd_valid && o_cmd_ready;
   assign w_busy    = (r_state == ST_WR) || (r_state == ST_WR_RESP) ||
                      (r_state == ST_RD_ADDR) || (r_state == ST_RD_DATA);
   assign w_tmo_hit = LP_TMO_EN && (r_tcnt == LP_TMO_LAST);
   assign w_abort   = w_busy && w_tmo_hit && !w_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // A completing handshake always takes priority over the watchdog in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_cmd_hs) w_state_nxt = i_cmd_write ? ST_WR : ST_RD_ADDR;
         end
         ST_WR: begin
            w_done = (!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready);
            if (w_done)         w_state_nxt = ST_WR_RESP;
            else if (w_tmo_hit) w_state_nxt = ST_RSP;
         end
         ST_WR_RESP: begin
            w_done = m_axi_bvalid && r_bready;
            if (w_done || w_tmo_hit) w_state_nxt = ST_RSP;
         end
         ST_RD_ADDR: begin
            w_done = r_arvalid && m_axi_arready;
            if (w_done)         w_state_nxt = ST_RD_DATA;
            else if (w_tmo_hit) w_state_nxt = ST_RSP;
         end
         ST_RD_DATA: begin
            w_done = m_axi_rvalid && r_rready;
            if (w_done || w_tmo_hit) w_state_nxt = ST_RSP;
         end
         ST_RSP: begin
            if (i_rsp_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_tcnt        <= '0;
         r_awaddr      <= '0;
         r_araddr      <= '0;
         r_wdata       <= '0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= 2'b00;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_busy) r_tcnt <= r_tcnt + 16'd1;
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_hs) begin
                  r_tcnt <= '0;
                  if (i_cmd_write) begin
                     r_awaddr  <= i_cmd_addr;
                     r_wdata   <= i_cmd_wdata;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_araddr  <= i_cmd_addr;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            ST_WR: begin
               if (m_axi_awready) r_awvalid <= 1'b0;
               if (m_axi_wready)  r_wvalid  <= 1'b0;
               if (w_done)        r_bready  <= 1'b1;
            end
            ST_WR_RESP: begin
               if (w_done) begin
                  r_bready      <= 1'b0;
                  r_rsp_rdata   <= '0;
                  r_rsp_resp    <= m_axi_bresp;
                  r_rsp_timeout <= 1'b0;
               end
            end
            ST_RD_ADDR: begin
               if (w_done) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end
            end
            ST_RD_DATA: begin
               if (w_done) begin
                  r_rready      <= 1'b0;
                  r_rsp_rdata   <= m_axi_rdata;
                  r_rsp_resp    <= m_axi_rresp;
                  r_rsp_timeout <= 1'b0;
               end
            end
            default: ;
         endcase
         // Abort overrides whatever the channel logic above scheduled.
         if (w_abort) begin
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b11;
            r_rsp_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_uart_master.sv
// Directed bench for axi_lite_uart_master: configurable AXI-Lite slave model,
// handshake monitor and a response scoreboard.
module tb_axi_lite_uart_master;

   localparam int DW  = 32;
   localparam int AW  = 16;
   localparam int TMO = 16;

   typedef struct packed {
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic        tmo;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
   logic [AW-1:0] i_cmd_addr;
   logic [DW-1:0] i_cmd_wdata;
   logic          o_rsp_valid, i_rsp_ready, o_rsp_timeout;
   logic [DW-1:0] o_rsp_rdata;
   logic [1:0]    o_rsp_resp;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [DW-1:0] m_axi_wdata, s_rdata;
   logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
   logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]    s_bresp, s_rresp;

   int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
   bit          cfg_w_never = 1'b0, cfg_ar_never = 1'b0, cfg_r_never = 1'b0;
   logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   logic [31:0] cfg_rdata = 32'h0;

   int sl_aw_c = 0, sl_w_c = 0, sl_b_c = 0, sl_ar_c = 0, sl_r_c = 0;
   int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, rsp_hs = 0;
   int aw_hi = 0, w_hi = 0, ar_hi = 0;
   logic [AW-1:0] mon_awaddr = '0, mon_araddr = '0;
   logic [DW-1:0] mon_wdata = '0;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk = ~clk;

   axi_lite_uart_master #(
      .P_M_AXI_DATA_WIDTH (DW),
      .P_M_AXI_ADDR_WIDTH (AW),
      .P_TIMEOUT          (TMO)
   ) dut (
      .clock         (clk),
      .reset         (rst),
      .i_cmd_valid   (i_cmd_valid),
      .o_cmd_ready   (o_cmd_ready),
      .i_cmd_write   (i_cmd_write),
      .i_cmd_addr    (i_cmd_addr),
      .i_cmd_wdata   (i_cmd_wdata),
      .o_rsp_valid   (o_rsp_valid),
      .i_rsp_ready   (i_rsp_ready),
      .o_rsp_rdata   (o_rsp_rdata),
      .o_rsp_resp    (o_rsp_resp),
      .o_rsp_timeout (o_rsp_timeout),
      .m_axi_awaddr  (m_axi_awaddr),
      .m_axi_awvalid (m_axi_awvalid),
      .m_axi_awready (s_awready),
      .m_axi_wdata   (m_axi_wdata),
      .m_axi_wvalid  (m_axi_wvalid),
      .m_axi_wready  (s_wready),
      .m_axi_bresp   (s_bresp),
      .m_axi_bvalid  (s_bvalid),
      .m_axi_bready  (m_axi_bready),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (s_arready),
      .m_axi_rdata   (s_rdata),
      .m_axi_rresp   (s_rresp),
      .m_axi_rvalid  (s_rvalid),
      .m_axi_rready  (m_axi_rready)
   );

   // Slave model: each channel answers after its configured number of cycles.
   initial begin
      s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0;
      s_bresp = 0; s_rresp = 0; s_rdata = 0;
      forever begin
         @(negedge clk);
         if (m_axi_awvalid) begin
            if (sl_aw_c >= cfg_aw_dly) s_awready = 1; else sl_aw_c++;
         end else begin s_awready = 0; sl_aw_c = 0; end
         if (m_axi_wvalid && !cfg_w_never) begin
            if (sl_w_c >= cfg_w_dly) s_wready = 1; else sl_w_c++;
         end else begin s_wready = 0; sl_w_c = 0; end
         if (m_axi_bready) begin
            if (sl_b_c >= cfg_b_dly) begin s_bvalid = 1; s_bresp = cfg_bresp; end else sl_b_c++;
         end else begin s_bvalid = 0; sl_b_c = 0; end
         if (m_axi_arvalid && !cfg_ar_never) begin
            if (sl_ar_c >= cfg_ar_dly) s_arready = 1; else sl_ar_c++;
         end else begin s_arready = 0; sl_ar_c = 0; end
         if (m_axi_rready && !cfg_r_never) begin
            if (sl_r_c >= cfg_r_dly) begin
               s_rvalid = 1; s_rdata = cfg_rdata; s_rresp = cfg_rresp;
            end else sl_r_c++;
         end else begin s_rvalid = 0; sl_r_c = 0; end
      end
   end

   always @(posedge clk) begin
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid)  w_hi++;
      if (m_axi_arvalid) ar_hi++;
      if (m_axi_awvalid && s_awready) begin aw_hs++; mon_awaddr = m_axi_awaddr; end
      if (m_axi_wvalid && s_wready)   begin w_hs++;  mon_wdata  = m_axi_wdata;  end
      if (m_axi_arvalid && s_arready) begin ar_hs++; mon_araddr = m_axi_araddr; end
      if (s_bvalid && m_axi_bready) b_hs++;
      if (s_rvalid && m_axi_rready) r_hs++;
      if (o_rsp_valid && i_rsp_ready) rsp_hs++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed time %0t required earlier end", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] r, input logic [1:0] s, input logic t);
      exp_t e;
      e.rdata = r;
      e.resp  = s;
      e.tmo   = t;
      return e;
   endfunction

   task automatic clr_mon();
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; rsp_hs = 0;
      aw_hi = 0; w_hi = 0; ar_hi = 0;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
      chk({tag, "_rsp_rdata"}, o_rsp_rdata, 32'd0);
      chk({tag, "_rsp_resp"}, 32'(o_rsp_resp), 32'd0);
      chk({tag, "_rsp_tmo"}, 32'(o_rsp_timeout), 32'd0);
      chk({tag, "_valids"}, 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'd0);
      chk({tag, "_readies"}, 32'({m_axi_bready, m_axi_rready}), 32'd0);
      chk({tag, "_awaddr"}, 32'(m_axi_awaddr), 32'd0);
      chk({tag, "_araddr"}, 32'(m_axi_araddr), 32'd0);
      chk({tag, "_wdata"}, m_axi_wdata, 32'd0);
   endtask

   // Called at a negedge; returns at the negedge after the command handshake.
   task automatic send_cmd(input string tag, input logic wr, input logic [15:0] a,
                           input logic [31:0] d, input bit push, input exp_t e);
      int n = 0;
      i_cmd_valid = 1; i_cmd_write = wr; i_cmd_addr = a; i_cmd_wdata = d;
      #1;
      while (o_cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      chk({tag, "_cmd_ready"}, 32'(o_cmd_ready), 32'd1);
      @(posedge clk);
      if (push) sb.push_back(e);
      @(negedge clk);
      i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_wdata = '0;
   endtask

   task automatic get_rsp(input string tag, input int hold);
      exp_t e;
      int   n = 0;
      while (o_rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk({tag, "_rsp_arrive"}, 32'(o_rsp_valid), 32'd1);
      if (o_rsp_valid !== 1'b1) return;
      chk({tag, "_sb_empty"}, 32'(sb.size() == 0), 32'd0);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      for (int k = 0; k <= hold; k++) begin
         if (k > 0) @(negedge clk);
         chk({tag, "_rsp_valid_held"}, 32'(o_rsp_valid), 32'd1);
         chk({tag, "_rdata"}, o_rsp_rdata, e.rdata);
         chk({tag, "_resp"}, 32'(o_rsp_resp), 32'(e.resp));
         chk({tag, "_tmo"}, 32'(o_rsp_timeout), 32'(e.tmo));
      end
      i_rsp_ready = 1;
      @(negedge clk);
      i_rsp_ready = 0;
      chk({tag, "_rsp_done"}, 32'(o_rsp_valid), 32'd0);
      chk({tag, "_ready_again"}, 32'(o_cmd_ready), 32'd1);
   endtask

   initial begin
      i_cmd_valid = 0; i_cmd_write = 0; i_cmd_addr = '0; i_cmd_wdata = '0; i_rsp_ready = 0;
      rst = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 0;
      chk_reset_state("rst0");

      clr_mon();
      send_cmd("wr_basic", 1'b1, 16'h0004, 32'h55, 1'b1, mk(32'h0, 2'b00, 1'b0));
      get_rsp("wr_basic", 0);
      chk("wr_basic_aw_hs", aw_hs, 1);
      chk("wr_basic_w_hs", w_hs, 1);
      chk("wr_basic_b_hs", b_hs, 1);
      chk("wr_basic_rsp_hs", rsp_hs, 1);
      chk("wr_basic_awaddr", 32'(mon_awaddr), 32'h0004);
      chk("wr_basic_wdata", mon_wdata, 32'h55);

      clr_mon();
      cfg_w_dly = 3;
      send_cmd("wr_wlate", 1'b1, 16'h000C, 32'hA5A5_1234, 1'b1, mk(32'h0, 2'b00, 1'b0));
      get_rsp("wr_wlate", 0);
      cfg_w_dly = 0;
      chk("wr_wlate_aw_hi", aw_hi, 1);
      chk("wr_wlate_w_hi", w_hi, 4);
      chk("wr_wlate_w_hs", w_hs, 1);
      chk("wr_wlate_rsp_hs", rsp_hs, 1);
      chk("wr_wlate_wdata", mon_wdata, 32'hA5A5_1234);

      clr_mon();
      cfg_r_dly = 2; cfg_rdata = 32'h0800_0032;
      send_cmd("rd_basic", 1'b0, 16'h0008, 32'hFFFF_FFFF, 1'b1, mk(32'h0800_0032, 2'b00, 1'b0));
      get_rsp("rd_basic", 0);
      cfg_r_dly = 0;
      chk("rd_basic_araddr", 32'(mon_araddr), 32'h0008);
      chk("rd_basic_ar_hs", ar_hs, 1);
      chk("rd_basic_r_hs", r_hs, 1);
      chk("rd_basic_no_aw", aw_hs, 0);

      cfg_bresp = 2'b10;
      send_cmd("wr_slverr", 1'b1, 16'h0000, 32'h41, 1'b1, mk(32'h0, 2'b10, 1'b0));
      get_rsp("wr_slverr", 0);
      cfg_bresp = 2'b00;

      cfg_rresp = 2'b11; cfg_rdata = 32'hDEAD_BEEF;
      send_cmd("rd_decerr", 1'b0, 16'h0004, 32'h0, 1'b1, mk(32'hDEAD_BEEF, 2'b11, 1'b0));
      get_rsp("rd_decerr", 0);
      cfg_rresp = 2'b00;

      clr_mon();
      cfg_ar_never = 1; cfg_rdata = 32'h1234_5678;
      send_cmd("rd_tmo", 1'b0, 16'h0010, 32'h0, 1'b1, mk(32'h0, 2'b11, 1'b1));
      get_rsp("rd_tmo", 0);
      cfg_ar_never = 0;
      chk("rd_tmo_ar_hi", ar_hi, TMO);
      chk("rd_tmo_ar_hs", ar_hs, 0);
      chk("rd_tmo_r_hs", r_hs, 0);

      cfg_rdata = 32'h1357_9BDF;
      send_cmd("rd_after_tmo", 1'b0, 16'h0014, 32'h0, 1'b1, mk(32'h1357_9BDF, 2'b00, 1'b0));
      get_rsp("rd_after_tmo", 0);

      clr_mon();
      cfg_ar_dly = TMO - 1; cfg_rdata = 32'hCAFE_0018;
      send_cmd("rd_edge", 1'b0, 16'h0018, 32'h0, 1'b1, mk(32'hCAFE_0018, 2'b00, 1'b0));
      get_rsp("rd_edge", 0);
      cfg_ar_dly = 0;
      chk("rd_edge_ar_hi", ar_hi, TMO);
      chk("rd_edge_r_hs", r_hs, 1);

      clr_mon();
      cfg_w_never = 1;
      send_cmd("wr_tmo", 1'b1, 16'h001C, 32'h77, 1'b1, mk(32'h0, 2'b11, 1'b1));
      get_rsp("wr_tmo", 0);
      cfg_w_never = 0;
      chk("wr_tmo_w_hi", w_hi, TMO);
      chk("wr_tmo_aw_hs", aw_hs, 1);
      chk("wr_tmo_w_hs", w_hs, 0);
      chk("wr_tmo_b_hs", b_hs, 0);

      cfg_rdata = 32'h0BAD_F00D;
      send_cmd("rd_hold", 1'b0, 16'h0020, 32'h0, 1'b1, mk(32'h0BAD_F00D, 2'b00, 1'b0));
      get_rsp("rd_hold", 5);

      clr_mon();
      cfg_r_never = 1;
      send_cmd("rd_rst", 1'b0, 16'h0024, 32'h0, 1'b0, mk(32'h0, 2'b00, 1'b0));
      repeat (4) @(negedge clk);
      chk("rd_rst_rready", 32'(m_axi_rready), 32'd1);
      chk("rd_rst_busy", 32'(o_cmd_ready), 32'd0);
      rst = 1;
      @(negedge clk);
      chk_reset_state("rst_mid");
      rst = 0;
      cfg_r_never = 0;
      repeat (3) @(negedge clk);
      chk("rst_mid_no_rsp", rsp_hs + 32'(o_rsp_valid), 32'd0);

      cfg_rdata = 32'h600D_CAFE;
      send_cmd("rd_recover", 1'b0, 16'h0028, 32'h0, 1'b1, mk(32'h600D_CAFE, 2'b00, 1'b0));
      get_rsp("rd_recover", 0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
